// File: rtl/pipe_hazard_ctl.sv
// ID-stage hazard controller: EX/MEM operand forwarding, load-use / branch / MUL-DIV
// scoreboard stall generation, and a saturating stall-cycle counter.
module pipe_hazard_ctl #(
    parameter int XLEN            = 32,
    parameter int RW              = 5,
    parameter int MD_LAT          = 4,
    parameter int BRANCH_EX_STALL = 0,
    parameter int CW              = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_branch,
    input  logic            id_md,
    input  logic [RW-1:0]   id_md_rd,
    input  logic            flush,
    input  logic [XLEN-1:0] qa,
    input  logic [XLEN-1:0] qb,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic [RW-1:0]   ern,
    input  logic [XLEN-1:0] ealu,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [RW-1:0]   mrn,
    input  logic [XLEN-1:0] malu,
    input  logic [XLEN-1:0] mmo,
    output logic [XLEN-1:0] da,
    output logic [XLEN-1:0] db,
    output logic            stall,
    output logic            wpcir,
    output logic            dbubble,
    output logic            md_busy,
    output logic [RW-1:0]   md_rd,
    output logic            md_done,
    output logic [CW-1:0]   stall_cnt
);

    localparam int CNTW = $clog2(MD_LAT + 1);
    localparam logic [CNTW-1:0] MD_LOAD = CNTW'(MD_LAT - 1);

    logic            r_md_busy;
    logic [RW-1:0]   r_md_rd;
    logic [CNTW-1:0] r_md_cnt;
    logic            r_md_done;
    logic [CW-1:0]   r_stall_cnt;

    logic            w_hz_rs;
    logic            w_hz_rt;
    logic            w_raw_stall;
    logic            w_stall;
    logic            w_issue;

    // EX has priority over MEM; r0 always reads the regfile value (which is zero).
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RW-1:0]   r,
        input logic [XLEN-1:0] q,
        input logic            e_wreg,
        input logic            e_m2reg,
        input logic [RW-1:0]   e_rn,
        input logic [XLEN-1:0] e_alu,
        input logic            m_wreg,
        input logic            m_m2reg,
        input logic [RW-1:0]   m_rn,
        input logic [XLEN-1:0] m_alu,
        input logic [XLEN-1:0] m_mo
    );
        logic [XLEN-1:0] v;
        v = q;
        if (r != '0) begin
            if (e_wreg && !e_m2reg && (e_rn == r)) begin
                v = e_alu;
            end else if (m_wreg && (m_rn == r)) begin
                v = m_m2reg ? m_mo : m_alu;
            end
        end
        return v;
    endfunction

    function automatic logic hazard(
        input logic          use_r,
        input logic [RW-1:0] r,
        input logic          branch,
        input logic          e_wreg,
        input logic          e_m2reg,
        input logic [RW-1:0] e_rn,
        input logic          sb_busy,
        input logic [RW-1:0] sb_rd
    );
        logic load_use;
        logic br;
        logic sb;
        load_use = e_wreg && e_m2reg && (e_rn == r);
        br       = (BRANCH_EX_STALL != 0) && branch && e_wreg && (e_rn == r);
        sb       = sb_busy && (sb_rd == r);
        return use_r && (r != '0) && (load_use || br || sb);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + CW'(1);
    endfunction

    always_comb begin
        da = fwd_sel(id_rs, qa, ewreg, em2reg, ern, ealu, mwreg, mm2reg, mrn, malu, mmo);
        db = fwd_sel(id_rt, qb, ewreg, em2reg, ern, ealu, mwreg, mm2reg, mrn, malu, mmo);
    end

    always_comb begin
        w_hz_rs     = hazard(id_use_rs, id_rs, id_branch, ewreg, em2reg, ern,
                             r_md_busy, r_md_rd);
        w_hz_rt     = hazard(id_use_rt, id_rt, id_branch, ewreg, em2reg, ern,
                             r_md_busy, r_md_rd);
        w_raw_stall = w_hz_rs || w_hz_rt || (id_md && r_md_busy);
        // A redirect kills the ID instruction, so its hazards are irrelevant.
        w_stall     = w_raw_stall && !flush;
        w_issue     = id_md && !w_stall && !flush && !r_md_busy;
    end

    // Scoreboard for the single multi-cycle unit; flush never cancels an op in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_md_busy <= 1'b0;
            r_md_rd   <= '0;
            r_md_cnt  <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_md_done <= 1'b0;
            if (r_md_busy) begin
                if (r_md_cnt != '0) begin
                    r_md_cnt <= r_md_cnt - CNTW'(1);
                end else begin
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b1;
                end
            end else if (w_issue) begin
                r_md_busy <= 1'b1;
                r_md_rd   <= id_md_rd;
                r_md_cnt  <= MD_LOAD;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    always_comb begin
        stall     = w_stall;
        wpcir     = !w_stall;
        dbubble   = w_stall || flush;
        md_busy   = r_md_busy;
        md_rd     = r_md_rd;
        md_done   = r_md_done;
        stall_cnt = r_stall_cnt;
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: dut_a uses defaults, dut_b has the branch stall
// enabled and a 2-bit stall counter; both share the same stimulus.
module tb_pipe_hazard_ctl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_md_rd, ern, mrn;
    logic        id_use_rs, id_use_rt, id_branch, id_md, flush;
    logic [31:0] qa, qb, ealu, malu, mmo;
    logic        ewreg, em2reg, mwreg, mm2reg;

    logic [31:0] da_a, db_a, da_b, db_b;
    logic        stall_a, wpcir_a, dbubble_a, md_busy_a, md_done_a;
    logic        stall_b, wpcir_b, dbubble_b, md_busy_b, md_done_b;
    logic [4:0]  md_rd_a, md_rd_b;
    logic [15:0] stall_cnt_a;
    logic [1:0]  stall_cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctl dut_a (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_md(id_md), .id_md_rd(id_md_rd), .flush(flush),
        .qa(qa), .qb(qb), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
        .da(da_a), .db(db_a), .stall(stall_a), .wpcir(wpcir_a), .dbubble(dbubble_a),
        .md_busy(md_busy_a), .md_rd(md_rd_a), .md_done(md_done_a), .stall_cnt(stall_cnt_a)
    );

    pipe_hazard_ctl #(.BRANCH_EX_STALL(1), .CW(2)) dut_b (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_md(id_md), .id_md_rd(id_md_rd), .flush(flush),
        .qa(qa), .qb(qb), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
        .da(da_b), .db(db_b), .stall(stall_b), .wpcir(wpcir_b), .dbubble(dbubble_b),
        .md_busy(md_busy_b), .md_rd(md_rd_b), .md_done(md_done_b), .stall_cnt(stall_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
        id_md = 0; id_md_rd = '0; flush = 0; qa = '0; qb = '0;
        ewreg = 0; em2reg = 0; ern = '0; ealu = '0;
        mwreg = 0; mm2reg = 0; mrn = '0; malu = '0; mmo = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        clr_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        settle();
        chk("rst_busy",   {31'd0, md_busy_a}, 32'd0);
        chk("rst_done",   {31'd0, md_done_a}, 32'd0);
        chk("rst_md_rd",  {27'd0, md_rd_a},   32'd0);
        chk("rst_cnt_a",  {16'd0, stall_cnt_a}, 32'd0);
        chk("rst_cnt_b",  {30'd0, stall_cnt_b}, 32'd0);
        chk("rst_stall",  {31'd0, stall_a},   32'd0);

        // 1: ALU forwarding, EX over MEM, then MEM ALU, MEM load, regfile
        do_reset();
        ewreg = 1; ern = 5'd3; ealu = 32'h11;
        mwreg = 1; mrn = 5'd3; malu = 32'h22; mmo = 32'h33;
        id_rs = 5'd3; id_use_rs = 1; id_rt = 5'd3; id_use_rt = 1;
        qa = 32'h99; qb = 32'h98;
        settle();
        chk("fwd_ex_da", da_a, 32'h11);
        chk("fwd_ex_db", db_a, 32'h11);
        chk("fwd_ex_stall", {31'd0, stall_a}, 32'd0);
        ern = 5'd4;
        settle();
        chk("fwd_mem_alu", da_a, 32'h22);
        mm2reg = 1;
        settle();
        chk("fwd_mem_ld", db_a, 32'h33);
        mrn = 5'd6;
        settle();
        chk("fwd_none_da", da_a, 32'h99);
        chk("fwd_none_db", db_a, 32'h98);

        // 2: load-use stall then MEM load forwarding
        do_reset();
        ewreg = 1; em2reg = 1; ern = 5'd5;
        id_rs = 5'd5; id_use_rs = 1; qa = 32'h1;
        settle();
        chk("lu_stall",   {31'd0, stall_a},   32'd1);
        chk("lu_wpcir",   {31'd0, wpcir_a},   32'd0);
        chk("lu_dbubble", {31'd0, dbubble_a}, 32'd1);
        tick();
        ewreg = 0; em2reg = 0; ern = '0;
        mwreg = 1; mm2reg = 1; mrn = 5'd5; mmo = 32'hBEEF;
        settle();
        chk("lu_fwd_da",  da_a, 32'hBEEF);
        chk("lu_release", {31'd0, stall_a}, 32'd0);
        chk("lu_cnt",     {16'd0, stall_cnt_a}, 32'd1);
        // unused operand never stalls
        ewreg = 1; em2reg = 1; ern = 5'd8; id_rt = 5'd8; id_use_rt = 0;
        settle();
        chk("lu_unused_rt", {31'd0, stall_a}, 32'd0);

        // 3: r0 never forwards nor stalls
        do_reset();
        ewreg = 1; em2reg = 0; ern = 5'd0; ealu = 32'h55;
        id_rs = 5'd0; id_use_rs = 1; qa = 32'h0;
        settle();
        chk("r0_da", da_a, 32'h0);
        em2reg = 1;
        settle();
        chk("r0_stall", {31'd0, stall_a}, 32'd0);

        // 4: MUL/DIV scoreboard, MD_LAT=4
        do_reset();
        id_md = 1; id_md_rd = 5'd7;
        settle();
        chk("md_issue_stall", {31'd0, stall_a}, 32'd0);
        tick();
        id_md = 0; id_md_rd = '0; id_rs = 5'd7; id_use_rs = 1;
        settle();
        chk("md_busy", {31'd0, md_busy_a}, 32'd1);
        chk("md_rd",   {27'd0, md_rd_a},   32'd7);
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk($sformatf("md_stall_c%0d", c), {31'd0, stall_a}, 32'd1);
            chk($sformatf("md_done_c%0d", c), {31'd0, md_done_a}, 32'd0);
            tick();
        end
        settle();
        chk("md_done_c5",  {31'd0, md_done_a}, 32'd1);
        chk("md_stall_c5", {31'd0, stall_a},   32'd0);
        chk("md_busy_c5",  {31'd0, md_busy_a}, 32'd0);
        chk("md_cnt_a",    {16'd0, stall_cnt_a}, 32'd4);
        chk("md_cnt_b",    {30'd0, stall_cnt_b}, 32'd3);
        tick();
        chk("md_done_c6",  {31'd0, md_done_a}, 32'd0);

        // flush during busy: op keeps counting, done still at cycle 5
        do_reset();
        id_md = 1; id_md_rd = 5'd9;
        tick();
        id_md = 0; flush = 1; id_rs = 5'd9; id_use_rs = 1;
        settle();
        chk("fl_md_stall", {31'd0, stall_a}, 32'd0);
        tick();
        flush = 0;
        tick(); tick(); tick();
        chk("fl_md_done", {31'd0, md_done_a}, 32'd1);

        // 5: flush beats load-use; branch stall only when enabled
        do_reset();
        ewreg = 1; em2reg = 1; ern = 5'd5; id_rs = 5'd5; id_use_rs = 1; flush = 1;
        settle();
        chk("fl_stall",   {31'd0, stall_a},   32'd0);
        chk("fl_dbubble", {31'd0, dbubble_a}, 32'd1);
        chk("fl_wpcir",   {31'd0, wpcir_a},   32'd1);
        tick();
        chk("fl_cnt", {16'd0, stall_cnt_a}, 32'd0);
        flush = 0; em2reg = 0; ern = 5'd9; id_rs = 5'd9; id_branch = 1;
        settle();
        chk("br_off_stall", {31'd0, stall_a}, 32'd0);
        chk("br_on_stall",  {31'd0, stall_b}, 32'd1);
        tick();
        ewreg = 0;
        settle();
        chk("br_on_release", {31'd0, stall_b}, 32'd0);
        chk("br_on_cnt", {30'd0, stall_cnt_b}, 32'd1);

        // 6: counter saturation and reset mid-op
        do_reset();
        ewreg = 1; em2reg = 1; ern = 5'd2; id_rt = 5'd2; id_use_rt = 1;
        repeat (5) tick();
        chk("sat_cnt_b", {30'd0, stall_cnt_b}, 32'd3);
        chk("sat_cnt_a", {16'd0, stall_cnt_a}, 32'd5);
        clr_inputs();
        id_md = 1; id_md_rd = 5'd4;
        tick();
        id_md = 0;
        chk("rst_mid_busy_pre", {31'd0, md_busy_a}, 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_busy", {31'd0, md_busy_a}, 32'd0);
        chk("rst_mid_cnt",  {30'd0, stall_cnt_b}, 32'd0);
        tick(); tick(); tick(); tick();
        chk("rst_mid_nodone", {31'd0, md_done_a}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
